// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: EXU/LSU share one write port, with a pending-load scoreboard for RAW/WAW.
// Optional EXU starvation guard enabled by defining RF_WB_STARVE_GUARD_EN.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5,
    parameter int STARVE_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   exu_valid,
    input  logic [REG_NUM_BIT-1:0] exu_rd,
    input  logic [DATA_WIDTH-1:0]  exu_wdata,
    output logic                   exu_ready,
    input  logic                   lsu_valid,
    input  logic [REG_NUM_BIT-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]  lsu_wdata,
    output logic                   lsu_ready,
    input  logic                   alloc_valid,
    input  logic [REG_NUM_BIT-1:0] alloc_rd,
    input  logic [REG_NUM_BIT-1:0] rs1,
    input  logic [REG_NUM_BIT-1:0] rs2,
    output logic                   hazard,
    output logic                   rf_wen,
    output logic [REG_NUM_BIT-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata
);

    logic [REG_NUM-1:0] busy, busy_nxt;
    logic exu_blocked, exu_xfer, lsu_xfer, starve_force;

    // An older load to the same rd must land before the EXU result (WAW).
    assign exu_blocked = busy[exu_rd] && (exu_rd != '0);

`ifdef RF_WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    logic [CW-1:0] starve_cnt;

    // Force only when EXU can actually go, so a blocked EXU never stalls the load that unblocks it.
    assign starve_force = exu_valid && !exu_blocked && (starve_cnt == CW'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (exu_xfer || !exu_valid)
            starve_cnt <= '0;
        else if (!exu_blocked && lsu_valid && starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    assign starve_force = 1'b0;
`endif

    assign lsu_ready = lsu_valid && !starve_force;
    assign exu_ready = exu_valid && !exu_blocked && (!lsu_valid || starve_force);
    assign lsu_xfer  = lsu_valid && lsu_ready;
    assign exu_xfer  = exu_valid && exu_ready;

    assign hazard = ((rs1 != '0) && busy[rs1]) || ((rs2 != '0) && busy[rs2]);

    // Alloc is applied after the clear so a same-cycle reallocation keeps rd pending.
    always_comb begin
        busy_nxt = busy;
        if (lsu_xfer)
            busy_nxt[lsu_rd] = 1'b0;
        if (alloc_valid)
            busy_nxt[alloc_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= 1'b0;
            if (lsu_xfer && lsu_rd != '0) begin
                rf_wen   <= 1'b1;
                rf_waddr <= lsu_rd;
                rf_wdata <= lsu_wdata;
            end else if (exu_xfer && exu_rd != '0) begin
                rf_wen   <= 1'b1;
                rf_waddr <= exu_rd;
                rf_wdata <= exu_wdata;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed plan checks plus randomized traffic against a behavioural model.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int RB = 5;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    logic exu_valid, exu_ready, lsu_valid, lsu_ready, alloc_valid, hazard, rf_wen;
    logic [RB-1:0] exu_rd, lsu_rd, alloc_rd, rs1, rs2, rf_waddr;
    logic [DW-1:0] exu_wdata, lsu_wdata, rf_wdata;

    int total = 0;
    int bad = 0;

    // model state
    bit [31:0] m_busy = '0;
    bit        m_wen = 1'b0;
    bit [RB-1:0] m_waddr = '0;
    bit [DW-1:0] m_wdata = '0;
    int        m_cnt = 0;

    // DUT values seen at the last sample point, for literal expectations
    logic last_l, last_e, last_h;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .REG_NUM(32), .REG_NUM_BIT(RB), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_wdata(exu_wdata), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata), .lsu_ready(lsu_ready),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        exu_valid = 0; lsu_valid = 0; alloc_valid = 0;
        exu_rd = 0; lsu_rd = 0; alloc_rd = 0; rs1 = 0; rs2 = 0;
        exu_wdata = 0; lsu_wdata = 0;
    endtask

    // One clock: compare at negedge against the model, then advance the model at posedge.
    task automatic cyc();
        bit blk, frc, e_l, e_e, e_h;
        @(negedge clk);
        blk = m_busy[exu_rd] && exu_rd != 0;
        frc = 1'b0;
`ifdef RF_WB_STARVE_GUARD_EN
        frc = exu_valid && !blk && m_cnt == SMAX;
`endif
        e_l = lsu_valid && !frc;
        e_e = exu_valid && !blk && (!lsu_valid || frc);
        e_h = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]);
        chk("lsu_ready", lsu_ready, e_l);
        chk("exu_ready", exu_ready, e_e);
        chk("hazard", hazard, e_h);
        chk("rf_wen", rf_wen, m_wen);
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
        last_l = lsu_ready; last_e = exu_ready; last_h = hazard;
        @(posedge clk);
        if (rst) begin
            m_busy = '0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
        end else begin
            m_wen = 0;
            if (e_l && lsu_rd != 0) begin
                m_wen = 1; m_waddr = lsu_rd; m_wdata = lsu_wdata;
            end else if (e_e && exu_rd != 0) begin
                m_wen = 1; m_waddr = exu_rd; m_wdata = exu_wdata;
            end
            if (e_l) m_busy[lsu_rd] = 1'b0;
            if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
            if (e_e || !exu_valid) m_cnt = 0;
            else if (!blk && lsu_valid && m_cnt < SMAX) m_cnt++;
        end
        #1;
    endtask

    initial begin
        logic [5:0] epat, lpat;
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        cyc();
        chk("reset_rf_wen", rf_wen, 1'b0);

        // single EXU write, one-cycle latency
        exu_valid = 1; exu_rd = 5; exu_wdata = 32'h1234;
        cyc();
        chk("t1_exu_ready", last_e, 1'b1);
        chk("t1_wen", rf_wen, 1'b1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, 32'h1234);
        idle();
        cyc();
        chk("t1_wen_drop", rf_wen, 1'b0);

        // LSU beats EXU
        exu_valid = 1; exu_rd = 3; exu_wdata = 32'hA;
        lsu_valid = 1; lsu_rd = 4; lsu_wdata = 32'hB;
        cyc();
        chk("t2_lsu_first", {last_l, last_e}, 2'b10);
        chk("t2_waddr", rf_waddr, 4);
        chk("t2_wdata", rf_wdata, 32'hB);
        lsu_valid = 0;
        cyc();
        chk("t2_exu_next", last_e, 1'b1);
        chk("t2_waddr2", rf_waddr, 3);
        chk("t2_wdata2", rf_wdata, 32'hA);

        // RAW hazard and WAW guard on rd 7
        idle();
        alloc_valid = 1; alloc_rd = 7;
        cyc();
        alloc_valid = 0; rs1 = 7;
        exu_valid = 1; exu_rd = 7; exu_wdata = 32'h77;
        cyc();
        chk("t3_hazard", last_h, 1'b1);
        chk("t3_exu_blocked", last_e, 1'b0);
        lsu_valid = 1; lsu_rd = 7; lsu_wdata = 32'h55;
        cyc();
        chk("t3_lsu_go", last_l, 1'b1);
        chk("t3_load_data", rf_wdata, 32'h55);
        lsu_valid = 0;
        cyc();
        chk("t3_exu_after", last_e, 1'b1);
        chk("t3_hazard_clr", last_h, 1'b0);
        chk("t3_exu_data", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd7, 32'h77});

        // x0 handling
        idle();
        exu_valid = 1; exu_rd = 0; exu_wdata = 32'hFFFF;
        cyc();
        chk("t4_x0_ready", last_e, 1'b1);
        chk("t4_x0_nowrite", rf_wen, 1'b0);
        idle();
        alloc_valid = 1; alloc_rd = 0;
        cyc();
        alloc_valid = 0; rs1 = 0;
        cyc();
        chk("t4_x0_hazard", last_h, 1'b0);

        // same-cycle alloc and clear of rd 9
        idle();
        alloc_valid = 1; alloc_rd = 9;
        cyc();
        lsu_valid = 1; lsu_rd = 9; lsu_wdata = 32'h99; rs2 = 9;
        cyc();
        chk("t5_lsu_go", last_l, 1'b1);
        idle(); rs2 = 9;
        cyc();
        chk("t5_still_busy", last_h, 1'b1);

        // continuous contention
        idle();
        cyc();
        exu_valid = 1; exu_rd = 2; exu_wdata = 32'h22;
        lsu_valid = 1; lsu_rd = 10; lsu_wdata = 32'h10;
        for (int i = 0; i < 6; i++) begin
            cyc();
            epat[i] = last_e; lpat[i] = last_l;
        end
`ifdef RF_WB_STARVE_GUARD_EN
        chk("t6_exu_pattern", epat, 6'b010000);
        chk("t6_lsu_pattern", lpat, 6'b101111);
`else
        chk("t6_exu_pattern", epat, 6'b000000);
        chk("t6_lsu_pattern", lpat, 6'b111111);
`endif

        // reset mid-operation
        rst = 1;
        cyc();
        chk("t7_wen_after_rst", rf_wen, 1'b0);
        rst = 0;
        idle(); rs1 = 9;
        cyc();
        chk("t7_busy_cleared", last_h, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            exu_valid   = $urandom_range(0, 1);
            exu_rd      = RB'($urandom_range(0, 7));
            exu_wdata   = $urandom;
            lsu_valid   = ($urandom_range(0, 2) == 0);
            lsu_rd      = RB'($urandom_range(0, 7));
            lsu_wdata   = $urandom;
            alloc_valid = ($urandom_range(0, 3) == 0);
            alloc_rd    = RB'($urandom_range(0, 7));
            rs1         = RB'($urandom_range(0, 7));
            rs2         = RB'($urandom_range(0, 7));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources:
  - EXU: single-cycle ALU results.
  - LSU: multi-cycle load results.
- Keeps a per-register pending-load scoreboard, used to:
  - flag RAW hazards to issue;
  - prevent WAW reordering between EXU and LSU.
- Sits between the EXU/LSU writeback stages and the register file write port (wen/waddr/wdata).

Parameters:
- DATA_WIDTH, 32, width of register data.
- REG_NUM, 32, number of architectural registers.
- REG_NUM_BIT, 5, register index width.
- STARVE_MAX, 4, consecutive EXU losses before forced EXU grant (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- exu_valid  input  1  EXU has a writeback.
- exu_rd  input  REG_NUM_BIT  EXU destination.
- exu_wdata  input  DATA_WIDTH  EXU result.
- exu_ready  output  1  EXU writeback accepted this cycle.
- lsu_valid  input  1  LSU has a load result.
- lsu_rd  input  REG_NUM_BIT  LSU destination.
- lsu_wdata  input  DATA_WIDTH  load data.
- lsu_ready  output  1  LSU writeback accepted this cycle.
- alloc_valid  input  1  issue dispatches a load; mark alloc_rd pending.
- alloc_rd  input  REG_NUM_BIT  load destination.
- rs1  input  REG_NUM_BIT  issue source 1 query.
- rs2  input  REG_NUM_BIT  issue source 2 query.
- hazard  output  1  rs1 or rs2 pending (combinational).
- rf_wen  output  1  register file write enable (registered).
- rf_waddr  output  REG_NUM_BIT  register file write address (registered).
- rf_wdata  output  DATA_WIDTH  register file write data (registered).

Behaviour:
- Reset:
  - busy[REG_NUM-1:0] = 0.
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0.
  - Starvation counter = 0.
  - Any in-flight writeback is dropped.
- Handshake: a transfer occurs when valid && ready in the same cycle. ready is combinational from the current-cycle valids and busy.
- Arbitration, strict priority:
  - lsu_ready = lsu_valid.
  - exu_ready = exu_valid && !lsu_valid && !exu_blocked.
  - exu_blocked = busy[exu_rd] && exu_rd != 0. This is the WAW guard: an older load to the same rd must write first.
  - At most one transfer per cycle.
- Write latency: one cycle. The cycle after a transfer, rf_wen = 1 with the winner's rd/wdata. Otherwise rf_wen = 0; rf_waddr/rf_wdata hold their last value.
- x0 handling:
  - Transfer to rd = 0 completes its handshake, but rf_wen stays 0.
  - alloc to x0 is ignored.
  - busy[0] is always 0.
- Scoreboard:
  - alloc_valid sets busy[alloc_rd] at the next edge.
  - LSU transfer clears busy[lsu_rd] at the next edge.
  - Same-cycle alloc and clear of the same rd: busy stays 1 (new load wins).
  - Alloc to an already-busy rd: busy stays 1.
- Hazard: hazard = (rs1 != 0 && busy[rs1]) || (rs2 != 0 && busy[rs2]). Reflects registered busy only; no same-cycle bypass of alloc or clear.
- LSU result arriving with busy[lsu_rd] = 0: still written; busy unchanged.
- Reset asserted mid-operation: next cycle rf_wen = 0 and busy is cleared regardless of valids.

Optional Feature:
- RF_WB_STARVE_GUARD_EN defined:
  - Counter increments each cycle exu_valid && !exu_blocked && lsu_valid, saturating at STARVE_MAX.
  - When counter == STARVE_MAX: EXU is granted and lsu_ready = 0 for that cycle.
  - Counter resets to 0 on any EXU transfer, or when exu_valid = 0.
- Undefined: strict LSU priority, no counter logic present.

Test Plan:
- Reset, then exu_valid = 1, rd = 5, wdata = 0x1234 -> exu_ready = 1; next cycle rf_wen = 1, rf_waddr = 5, rf_wdata = 0x1234; following cycle rf_wen = 0.
- EXU (rd = 3, 0xA) and LSU (rd = 4, 0xB) valid together -> LSU first (rf_waddr = 4, 0xB); EXU write rd = 3 lands one cycle later.
- alloc rd = 7; next cycle rs1 = 7 -> hazard = 1; EXU rd = 7 -> exu_ready = 0. LSU rd = 7 data 0x55 transfers -> busy clears; EXU rd = 7 then accepted and writes after the 0x55 write.
- EXU rd = 0, data 0xFFFF -> exu_ready = 1, rf_wen remains 0. alloc rd = 0, then rs1 = 0 -> hazard = 0.
- Same cycle: alloc rd = 9 and LSU transfer rd = 9 with busy[9] = 1 -> busy[9] stays 1, hazard for rs2 = 9 remains 1.
- With RF_WB_STARVE_GUARD_EN and STARVE_MAX = 4: LSU and EXU (rd = 2) valid continuously -> 4 LSU grants, then EXU granted on the 5th cycle (lsu_ready = 0); without the macro, EXU never granted. Then assert rst -> busy cleared, rf_wen = 0 next cycle.
